expand_a_sched: RTL and testbench

EXPAND_A_SCHED -- requirements
Module: expand_a_sched

---
 rtl/expand_a_sched.sv | 151 +++++++++++++++
 tb/tb_expand_a_sched.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expand_a_sched.sv
// Matrix-A expansion scheduler: walks (k,l) in row-major order and hands
// RejNTTPoly jobs to the lowest idle sampling channel, counting completions.
module expand_a_sched #(
  parameter int NCH       = 2,
  parameter int SEED_BITS = 256,
  parameter int KMAX      = 8,
  parameter int LMAX      = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [SEED_BITS-1:0]         rho,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [NCH-1:0]               ch_start,
  output logic [NCH*(SEED_BITS+16)-1:0] ch_rho,
  output logic [NCH*4-1:0]             ch_k,
  output logic [NCH*4-1:0]             ch_l,
  input  logic [NCH-1:0]               ch_done,
  output logic [6:0]                   polys_done
);

  localparam int SW = SEED_BITS + 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]           state;
  logic [3:0]           kdim, ldim, k_idx, l_idx;
  logic                 issued;
  logic [SEED_BITS-1:0] seed;
  logic [NCH-1:0]       act;

  logic [3:0]           mk, ml;
  logic [NCH-1:0]       acc, free, pick, disp;
  logic                 found, go, run_ok;
  logic [2:0]           n_acc;
  logic [3:0]           jk, jl, lim_k, lim_l;
  logic [SEED_BITS-1:0] jseed;
  logic                 last_l, last;
  logic [7:0]           total;

  always_comb begin
    mk = 4'(KMAX);
    ml = 4'(LMAX);
    unique case (mode)
      2'd0:    begin mk = 4'd4; ml = 4'd4; end
      2'd1:    begin mk = 4'd6; ml = 4'd5; end
      default: begin mk = 4'(KMAX); ml = 4'(LMAX); end
    endcase
  end

  // A channel finishing this cycle may be refilled by this cycle's decision;
  // the registered ch_start then lands in the following cycle.
  always_comb begin
    acc   = act & ch_done;
    free  = ~act | acc;
    pick  = '0;
    found = 1'b0;
    n_acc = 3'd0;
    for (int c = 0; c < NCH; c++) begin
      if (free[c] && !found) begin
        pick[c] = 1'b1;
        found   = 1'b1;
      end
      n_acc = n_acc + {2'b00, acc[c]};
    end
  end

  assign go     = (state == IDLE) && start && (mode != 2'd3) && !abort;
  assign run_ok = (state == RUN) && !issued && !abort;
  assign disp   = (go || run_ok) ? pick : '0;

  assign jk     = go ? 4'd0 : k_idx;
  assign jl     = go ? 4'd0 : l_idx;
  assign lim_k  = go ? mk : kdim;
  assign lim_l  = go ? ml : ldim;
  assign jseed  = go ? rho : seed;
  assign last_l = (jl == lim_l - 4'd1);
  assign last   = last_l && (jk == lim_k - 4'd1);
  assign total  = {4'b0000, kdim} * {4'b0000, ldim};

  assign busy = (state == RUN);
  assign done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kdim       <= 4'd0;
      ldim       <= 4'd0;
      k_idx      <= 4'd0;
      l_idx      <= 4'd0;
      issued     <= 1'b0;
      seed       <= '0;
      act        <= '0;
      err        <= 1'b0;
      ch_start   <= '0;
      ch_rho     <= '0;
      ch_k       <= '0;
      ch_l       <= '0;
      polys_done <= 7'd0;
    end else begin
      ch_start <= disp;
      err      <= (state == IDLE) && start && !abort && (mode == 2'd3);
      act      <= abort ? '0 : ((act & ~ch_done) | disp);

      if (go)
        polys_done <= 7'd0;
      else if (!abort)
        polys_done <= polys_done + {4'b0000, n_acc};

      if (go) begin
        kdim <= mk;
        ldim <= ml;
        seed <= rho;
      end

      if (|disp) begin
        k_idx  <= last_l ? jk + 4'd1 : jk;
        l_idx  <= last_l ? 4'd0 : jl + 4'd1;
        issued <= last;
      end

      for (int c = 0; c < NCH; c++) begin
        if (disp[c]) begin
          ch_rho[c*SW +: SW] <= {4'b0000, jk, 4'b0000, jl, jseed};
          ch_k[c*4 +: 4]     <= jk;
          ch_l[c*4 +: 4]     <= jl;
        end
      end

      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE:    if (go) state <= RUN;
          RUN:     if (issued && act == '0 &&
                       {1'b0, polys_done} == total)
                     state <= FINISH;
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_expand_a_sched.sv
// Scoreboard bench for expand_a_sched: a two-channel and a one-channel
// instance, each fed by stub samplers that complete after a set latency.
module tb_expand_a_sched;

  typedef struct packed {
    logic [3:0]   k;
    logic [3:0]   l;
    logic [271:0] seed;
  } job_t;

  logic clk;
  logic rst;

  logic         start_a, abort_a, busy_a, done_a, err_a;
  logic [1:0]   mode_a;
  logic [255:0] rho_a;
  logic [1:0]   ch_start_a, ch_done_a, stub_d_a, spur_a;
  logic [543:0] ch_rho_a;
  logic [7:0]   ch_k_a, ch_l_a;
  logic [6:0]   polys_done_a;

  logic         start_b, abort_b, busy_b, done_b, err_b;
  logic [1:0]   mode_b;
  logic [255:0] rho_b;
  logic         ch_start_b, ch_done_b;
  logic [271:0] ch_rho_b;
  logic [3:0]   ch_k_b, ch_l_b;
  logic [6:0]   polys_done_b;

  job_t qa[$];
  job_t qb[$];
  int   cnt_a[2];
  int   lat_a[2];
  int   cnt_b;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_starts_a = 0;
  int   n_done_a = 0;
  int   n_starts_b = 0;
  int   n_done_b = 0;

  expand_a_sched #(.NCH(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
    .rho(rho_a), .abort(abort_a), .busy(busy_a), .done(done_a),
    .err(err_a), .ch_start(ch_start_a), .ch_rho(ch_rho_a),
    .ch_k(ch_k_a), .ch_l(ch_l_a), .ch_done(ch_done_a),
    .polys_done(polys_done_a)
  );

  expand_a_sched #(.NCH(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
    .rho(rho_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .err(err_b), .ch_start(ch_start_b), .ch_rho(ch_rho_b),
    .ch_k(ch_k_b), .ch_l(ch_l_b), .ch_done(ch_done_b),
    .polys_done(polys_done_b)
  );

  assign ch_done_a = stub_d_a | spur_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stub samplers: done pulse a fixed latency after each launch.
  initial begin
    stub_d_a = 2'b00;
    ch_done_b = 1'b0;
    cnt_a[0] = 0;
    cnt_a[1] = 0;
    cnt_b = 0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        stub_d_a[c] = 1'b0;
        if (rst) cnt_a[c] = 0;
        else begin
          if (cnt_a[c] > 0) begin
            cnt_a[c]--;
            if (cnt_a[c] == 0) stub_d_a[c] = 1'b1;
          end
          if (ch_start_a[c]) cnt_a[c] = lat_a[c];
        end
      end
      ch_done_b = 1'b0;
      if (rst) cnt_b = 0;
      else begin
        if (cnt_b > 0) begin
          cnt_b--;
          if (cnt_b == 0) ch_done_b = 1'b1;
        end
        if (ch_start_b) cnt_b = 10;
      end
    end
  end

  // Scoreboard consumers.
  initial begin
    job_t e;
    forever begin
      @(negedge clk);
      if (done_a === 1'b1) n_done_a++;
      if (done_b === 1'b1) n_done_b++;
      if (ch_start_a !== 2'b00) begin
        n_starts_a++;
        n_checks++;
        if (!$onehot(ch_start_a)) begin
          n_fail++;
          $display("FAIL sb_a_onehot: got %b want one bit", ch_start_a);
        end
        for (int c = 0; c < 2; c++) begin
          if (ch_start_a[c]) begin
            n_checks++;
            if (qa.size() == 0) begin
              n_fail++;
              $display("FAIL sb_a_extra: ch%0d start k=%0d l=%0d unexpected",
                       c, ch_k_a[c*4 +: 4], ch_l_a[c*4 +: 4]);
            end else begin
              e = qa.pop_front();
              if ({ch_k_a[c*4 +: 4], ch_l_a[c*4 +: 4], ch_rho_a[c*272 +: 272]}
                  !== {e.k, e.l, e.seed}) begin
                n_fail++;
                $display("FAIL sb_a_job: ch%0d got k=%0d l=%0d tag=%h want k=%0d l=%0d tag=%h",
                         c, ch_k_a[c*4 +: 4], ch_l_a[c*4 +: 4],
                         ch_rho_a[c*272+256 +: 16], e.k, e.l, e.seed[271:256]);
              end
            end
          end
        end
      end
      if (ch_start_b === 1'b1) begin
        n_starts_b++;
        n_checks++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_b_extra: start k=%0d l=%0d unexpected", ch_k_b, ch_l_b);
        end else begin
          e = qb.pop_front();
          if ({ch_k_b, ch_l_b, ch_rho_b} !== {e.k, e.l, e.seed}) begin
            n_fail++;
            $display("FAIL sb_b_job: got k=%0d l=%0d rho=%h want k=%0d l=%0d rho=%h",
                     ch_k_b, ch_l_b, ch_rho_b, e.k, e.l, e.seed);
          end
        end
      end
    end
  end

  task automatic push_jobs(input int kk, input int ll, input logic [255:0] r,
                           input bit to_b);
    job_t j;
    for (int k = 0; k < kk; k++) begin
      for (int l = 0; l < ll; l++) begin
        j.k = 4'(k);
        j.l = 4'(l);
        j.seed = {8'(k), 8'(l), r};
        if (to_b) qb.push_back(j);
        else qa.push_back(j);
      end
    end
  endtask

  task automatic go_a(input logic [1:0] m, input logic [255:0] r);
    start_a = 1'b1;
    mode_a = m;
    rho_a = r;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_a = 1'b1;
    mode_a = 2'd0;
    rho_a = '1;
    abort_a = 1'b0;
    spur_a = 2'b00;
    start_b = 1'b0;
    mode_b = 2'd0;
    rho_b = '0;
    abort_b = 1'b0;
    lat_a[0] = 10;
    lat_a[1] = 10;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_a, done_a, err_a, ch_start_a, polys_done_a} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_ctl_a: got %h want 0",
               {busy_a, done_a, err_a, ch_start_a, polys_done_a});
    end
    n_checks++;
    if ({ch_rho_a, ch_k_a, ch_l_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_ch_a: got nonzero want 0");
    end
    n_checks++;
    if ({busy_b, done_b, err_b, ch_start_b, polys_done_b, ch_rho_b, ch_k_b, ch_l_b}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got nonzero want 0");
    end
    start_a = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0;
    logic [255:0] r;
    bit ok;
    r = {$urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom};
    n_starts_a = 0;
    n_done_a = 0;
    push_jobs(4, 4, r, 1'b0);
    go_a(2'd0, r);
    n_checks++;
    if ({busy_a, ch_start_a} !== 3'b101) begin
      n_fail++;
      $display("FAIL first_launch: got busy=%b ch_start=%b want 1 01",
               busy_a, ch_start_a);
    end
    repeat (15) @(negedge clk);
    go_a(2'd2, ~r);
    wait_done_a(400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mode0_timeout: got no done want done");
    end
    n_checks++;
    if (polys_done_a !== 7'd16) begin
      n_fail++;
      $display("FAIL mode0_count: got %0d want 16", polys_done_a);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({n_starts_a, n_done_a, qa.size()} !== {32'd16, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL mode0_totals: got starts=%0d done=%0d left=%0d want 16 1 0",
               n_starts_a, n_done_a, qa.size());
    end
    spur_a = 2'b11;
    @(negedge clk);
    spur_a = 2'b00;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy_a, polys_done_a} !== {1'b0, 7'd16} || n_starts_a != 16) begin
      n_fail++;
      $display("FAIL spurious_done: got busy=%b count=%0d starts=%0d want 0 16 16",
               busy_a, polys_done_a, n_starts_a);
    end
  endtask

  task automatic test_err;
    go_a(2'd3, '1);
    n_checks++;
    if ({err_a, busy_a, ch_start_a} !== 4'b1000) begin
      n_fail++;
      $display("FAIL err_pulse: got err=%b busy=%b ch_start=%b want 1 0 00",
               err_a, busy_a, ch_start_a);
    end
    @(negedge clk);
    n_checks++;
    if ({err_a, busy_a, ch_start_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL err_once: got err=%b busy=%b ch_start=%b want 0 0 00",
               err_a, busy_a, ch_start_a);
    end
  endtask

  task automatic test_abort;
    logic [255:0] r;
    logic [6:0] snap;
    int seen;
    bit ok;
    r = {8{$urandom}};
    n_starts_a = 0;
    n_done_a = 0;
    seen = 0;
    push_jobs(6, 5, r, 1'b0);
    go_a(2'd1, r);
    for (int i = 0; i < 200 && seen < 5; i++) begin
      if (ch_start_a !== 2'b00) seen++;
      if (seen < 5) @(negedge clk);
    end
    snap = polys_done_a;
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    n_checks++;
    if ({busy_a, ch_start_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b ch_start=%b want 0 00",
               busy_a, ch_start_a);
    end
    repeat (25) @(negedge clk);
    n_checks++;
    if (polys_done_a !== snap || n_done_a != 0 || n_starts_a != 5) begin
      n_fail++;
      $display("FAIL abort_frozen: got count=%0d done=%0d starts=%0d want %0d 0 5",
               polys_done_a, n_done_a, n_starts_a, snap);
    end
    qa.delete();
    start_a = 1'b1;
    abort_a = 1'b1;
    mode_a = 2'd0;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    n_checks++;
    if ({busy_a, err_a, ch_start_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_beats_start: got busy=%b err=%b ch_start=%b want 0 0 00",
               busy_a, err_a, ch_start_a);
    end
    n_starts_a = 0;
    n_done_a = 0;
    push_jobs(6, 5, ~r, 1'b0);
    go_a(2'd1, ~r);
    wait_done_a(600, ok);
    n_checks++;
    if (!ok || polys_done_a !== 7'd30) begin
      n_fail++;
      $display("FAIL rerun_after_abort: got done=%b count=%0d want 1 30",
               ok, polys_done_a);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_starts_a != 30 || n_done_a != 1 || qa.size() != 0) begin
      n_fail++;
      $display("FAIL rerun_totals: got starts=%0d done=%0d left=%0d want 30 1 0",
               n_starts_a, n_done_a, qa.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [255:0] r;
    logic [6:0] prev;
    bit ok;
    r = {8{$urandom}};
    lat_a[0] = 11;
    lat_a[1] = 10;
    push_jobs(4, 4, r, 1'b0);
    go_a(2'd0, r);
    prev = polys_done_a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (polys_done_a !== prev) break;
    end
    n_checks++;
    if (polys_done_a !== prev + 7'd2 || ch_start_a !== 2'b01) begin
      n_fail++;
      $display("FAIL dual_done_c1: got count=%0d ch_start=%b want %0d 01",
               polys_done_a, ch_start_a, prev + 7'd2);
    end
    @(negedge clk);
    n_checks++;
    if (ch_start_a !== 2'b10) begin
      n_fail++;
      $display("FAIL dual_done_c2: got ch_start=%b want 10", ch_start_a);
    end
    wait_done_a(400, ok);
    n_checks++;
    if (!ok || polys_done_a !== 7'd16) begin
      n_fail++;
      $display("FAIL dual_run: got done=%b count=%0d want 1 16", ok, polys_done_a);
    end
    lat_a[0] = 10;
    lat_a[1] = 10;
    @(negedge clk);
  endtask

  task automatic test_single_channel;
    logic [255:0] r;
    bit ok;
    r = {4{64'h1234567890abcdef}};
    n_starts_b = 0;
    n_done_b = 0;
    push_jobs(8, 7, r, 1'b1);
    start_b = 1'b1;
    mode_b = 2'd2;
    rho_b = r;
    @(negedge clk);
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_b === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || polys_done_b !== 7'd56) begin
      n_fail++;
      $display("FAIL single_run: got done=%b count=%0d want 1 56", ok, polys_done_b);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_starts_b != 56 || n_done_b != 1 || qb.size() != 0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL single_totals: got starts=%0d done=%0d left=%0d busy=%b want 56 1 0 0",
               n_starts_b, n_done_b, qb.size(), busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_err();
    test_abort();
    test_back_to_back();
    test_single_channel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
